// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit
//   Hazard unit for the segmented RV32I core. A shadow scoreboard records
//   {valid, rd, reg_write, mem_read} for every instruction between EX
//   (entry 0) and WB (entry NUM_STAGES-1). From that scoreboard the unit derives
//   the load-use stall, the branch flush and the EX operand forwarding selects.
//
// Ports
//   clk, reset                 core clock, synchronous active-high reset
//   id_valid                   ID holds a real instruction
//   id_rs1/id_rs2              source register addresses
//   id_use_rs1/id_use_rs2      instruction reads the corresponding source
//   id_rd                      destination register address
//   id_reg_write/id_mem_read   instruction writes rd / is a load
//   ex_branch_taken            branch or jump resolved taken in EX
//   stall                      hold PC and IF/ID, bubble into ID/EX
//   flush_if_id/flush_id_ex    clear IF/ID and ID/EX on the next edge
//   fwd_sel_a/fwd_sel_b        0 = register file, k = forward from entry k-1
//   stall_cycles               saturating count of stalled cycles
module hazard_scoreboard_unit #(
    parameter  int NUM_STAGES = 3,
    parameter  int LOAD_STAGE = 1,
    parameter  int REG_ADDR_W = 5,
    parameter  int CNT_W      = 16,
    localparam int SEL_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic                  stall,
    output logic                  flush_if_id,
    output logic                  flush_id_ex,
    output logic [SEL_W-1:0]      fwd_sel_a,
    output logic [SEL_W-1:0]      fwd_sel_b,
    output logic [CNT_W-1:0]      stall_cycles
);

    logic                  sb_vld [NUM_STAGES];
    logic [REG_ADDR_W-1:0] sb_rd  [NUM_STAGES];
    logic                  sb_wr  [NUM_STAGES];
    logic                  sb_ld  [NUM_STAGES];
    logic [CNT_W-1:0]      stall_cnt;

    logic [REG_ADDR_W-1:0] src  [2];
    logic                  used [2];
    logic [SEL_W-1:0]      sel  [2];
    logic                  luse [2];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign src[0]  = id_rs1;
    assign src[1]  = id_rs2;
    assign used[0] = id_use_rs1;
    assign used[1] = id_use_rs2;

    // Operand resolution: the scan runs from the oldest entry to the youngest,
    // so later hits overwrite earlier ones. luse ends up describing the
    // youngest match; sel ends up at the youngest entry whose data is actually
    // available (a load is only forwardable once it has reached LOAD_STAGE).
    always_comb begin
        for (int o = 0; o < 2; o++) begin
            sel[o]  = '0;
            luse[o] = 1'b0;
            for (int s = NUM_STAGES - 1; s >= 0; s--) begin
                if (sb_vld[s] && sb_wr[s] && (sb_rd[s] == src[o]) &&
                    (src[o] != '0) && used[o]) begin
                    luse[o] = sb_ld[s] && (s < LOAD_STAGE);
                    if (!sb_ld[s] || (s >= LOAD_STAGE)) begin
                        sel[o] = SEL_W'(s + 1);
                    end
                end
            end
        end
    end

    // A taken branch wins over a load-use stall; reset silences everything.
    assign stall        = !reset && !ex_branch_taken && id_valid && (luse[0] || luse[1]);
    assign flush_if_id  = !reset && ex_branch_taken;
    assign flush_id_ex  = !reset && ex_branch_taken;
    assign fwd_sel_a    = reset ? '0 : sel[0];
    assign fwd_sel_b    = reset ? '0 : sel[1];
    assign stall_cycles = reset ? '0 : stall_cnt;

    // ID -> EX boundary: entry 0 takes the ID instruction or a bubble, older
    // entries shift toward WB and the last one falls off.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NUM_STAGES; s++) begin
                sb_vld[s] <= 1'b0;
            end
            stall_cnt <= '0;
        end else begin
            sb_vld[0] <= id_valid && !stall && !ex_branch_taken;
            for (int s = 1; s < NUM_STAGES; s++) begin
                sb_vld[s] <= sb_vld[s-1];
            end
            if (stall) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // Payload of a bubble is never looked at, so it shifts without reset.
    always_ff @(posedge clk) begin
        sb_rd[0] <= id_rd;
        sb_wr[0] <= id_reg_write;
        sb_ld[0] <= id_mem_read;
        for (int s = 1; s < NUM_STAGES; s++) begin
            sb_rd[s] <= sb_rd[s-1];
            sb_wr[s] <= sb_wr[s-1];
            sb_ld[s] <= sb_ld[s-1];
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Bench for hazard_scoreboard_unit. Two instances share one input stream:
// dut0 in the default configuration, dut1 with NUM_STAGES=5, LOAD_STAGE=2 and
// a 3-bit stall counter so saturation is reached quickly. Each cycle the
// driver asks an instruction-level model what every output should be, queues
// that, and a monitor on the falling edge pops and compares.
module tb_hazard_scoreboard_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, id_valid, id_use_rs1, id_use_rs2;
    logic       id_reg_write, id_mem_read, ex_branch_taken;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic       st0, fi0, fe0;
    logic [1:0] fa0, fb0;
    logic [15:0] cnt0;
    logic       st1, fi1, fe1;
    logic [2:0] fa1, fb1;
    logic [2:0] cnt1;

    hazard_scoreboard_unit dut0 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .stall(st0), .flush_if_id(fi0), .flush_id_ex(fe0),
        .fwd_sel_a(fa0), .fwd_sel_b(fb0), .stall_cycles(cnt0)
    );

    hazard_scoreboard_unit #(
        .NUM_STAGES(5), .LOAD_STAGE(2), .REG_ADDR_W(5), .CNT_W(3)
    ) dut1 (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken),
        .stall(st1), .flush_if_id(fi1), .flush_id_ex(fe1),
        .fwd_sel_a(fa1), .fwd_sel_b(fb1), .stall_cycles(cnt1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
    } inst_t;

    typedef struct {
        int st, fl, fa, fb, cnt;       // model expectations
        int lst, lfl, lfa, lfb, lcnt;  // hand-derived expectations, -1 = none
    } item_t;

    inst_t       pipe [2][5];   // in-flight instructions, index = age in cycles
    int unsigned cnt_m [2];
    item_t       q0 [$];
    item_t       q1 [$];
    int          l_st [2], l_fl [2], l_fa [2], l_fb [2], l_cnt [2];
    int          vectors = 0;
    int          errors  = 0;

    function automatic int ns(input int k);   return (k == 0) ? 3 : 5;      endfunction
    function automatic int ls(input int k);   return (k == 0) ? 1 : 2;      endfunction
    function automatic int cmax(input int k); return (k == 0) ? 65535 : 7;  endfunction

    // Who produces register r most recently, and can its value be taken yet?
    function automatic void lookup(input int k, input logic [4:0] r, input logic u,
                                   output int sel, output bit luse);
        bit seen;
        seen = 0;
        sel  = 0;
        luse = 0;
        if (!u || r == 5'd0) return;
        for (int s = 0; s < ns(k); s++) begin
            if (pipe[k][s].v && pipe[k][s].wr && pipe[k][s].rd == r) begin
                if (!seen) begin
                    seen = 1;
                    luse = pipe[k][s].ld && (s < ls(k));
                end
                if (sel == 0 && (!pipe[k][s].ld || s >= ls(k))) sel = s + 1;
            end
        end
    endfunction

    function automatic void clr_lit();
        for (int k = 0; k < 2; k++) begin
            l_st[k] = -1; l_fl[k] = -1; l_fa[k] = -1; l_fb[k] = -1; l_cnt[k] = -1;
        end
    endfunction

    function automatic void setlit(input int k, input int st, input int fl,
                                   input int fa, input int fb, input int cnt);
        l_st[k] = st; l_fl[k] = fl; l_fa[k] = fa; l_fb[k] = fb; l_cnt[k] = cnt;
    endfunction

    function automatic void setlit2(input int st, input int fl, input int fa,
                                    input int fb, input int cnt);
        setlit(0, st, fl, fa, fb, cnt);
        setlit(1, st, fl, fa, fb, cnt);
    endfunction

    // One ID cycle: drive inputs, queue expectations, advance the model.
    task automatic issue(input bit r, input bit v, input int a, input int b,
                         input bit ua, input bit ub, input int d, input bit w,
                         input bit m, input bit bt);
        item_t it;
        int    sa, sb;
        bit    la, lb;
        @(posedge clk);
        #1;
        reset = r; id_valid = v; id_rs1 = 5'(a); id_rs2 = 5'(b);
        id_use_rs1 = ua; id_use_rs2 = ub; id_rd = 5'(d);
        id_reg_write = w; id_mem_read = m; ex_branch_taken = bt;
        for (int k = 0; k < 2; k++) begin
            lookup(k, 5'(a), ua, sa, la);
            lookup(k, 5'(b), ub, sb, lb);
            it.st  = int'(!r && !bt && v && (la || lb));
            it.fl  = int'(!r && bt);
            it.fa  = r ? 0 : sa;
            it.fb  = r ? 0 : sb;
            it.cnt = r ? 0 : int'(cnt_m[k]);
            it.lst = l_st[k]; it.lfl = l_fl[k]; it.lfa = l_fa[k];
            it.lfb = l_fb[k]; it.lcnt = l_cnt[k];
            if (k == 0) q0.push_back(it); else q1.push_back(it);
            if (r) begin
                for (int s = 0; s < 5; s++) pipe[k][s] = '0;
                cnt_m[k] = 0;
            end else begin
                for (int s = 4; s > 0; s--) pipe[k][s] = pipe[k][s-1];
                if (v && it.st == 0 && !bt) pipe[k][0] = {1'b1, 5'(d), w, m};
                else                        pipe[k][0] = '0;
                if (it.st != 0 && cnt_m[k] < cmax(k)) cnt_m[k]++;
            end
        end
        clr_lit();
    endtask

    task automatic alu(input int d, input int a, input int b);
        issue(0, 1, a, b, 1, 1, d, 1, 0, 0);
    endtask
    task automatic lw(input int d, input int a);
        issue(0, 1, a, 0, 1, 0, d, 1, 1, 0);
    endtask
    task automatic nop();
        issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic drain();
        repeat (5) nop();
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input int ex);
        vectors++;
        if (act !== 32'(ex)) begin
            errors++;
            $display("FAIL %s @%0t: got %0d, expected %0d", nm, $time, act, ex);
        end
    endtask

    task automatic chk_item(input string p, input item_t it, input logic st,
                            input logic fi, input logic fe, input logic [31:0] fa,
                            input logic [31:0] fb, input logic [31:0] cnt);
        chk({p, ".stall"},        32'(st), it.st);
        chk({p, ".flush_if_id"},  32'(fi), it.fl);
        chk({p, ".flush_id_ex"},  32'(fe), it.fl);
        chk({p, ".fwd_sel_a"},    fa,      it.fa);
        chk({p, ".fwd_sel_b"},    fb,      it.fb);
        chk({p, ".stall_cycles"}, cnt,     it.cnt);
        if (it.lst  >= 0) chk({p, ".stall(directed)"},        32'(st), it.lst);
        if (it.lfl  >= 0) chk({p, ".flush_if_id(directed)"},  32'(fi), it.lfl);
        if (it.lfl  >= 0) chk({p, ".flush_id_ex(directed)"},  32'(fe), it.lfl);
        if (it.lfa  >= 0) chk({p, ".fwd_sel_a(directed)"},    fa,      it.lfa);
        if (it.lfb  >= 0) chk({p, ".fwd_sel_b(directed)"},    fb,      it.lfb);
        if (it.lcnt >= 0) chk({p, ".stall_cycles(directed)"}, cnt,     it.lcnt);
    endtask

    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                it = q0.pop_front();
                chk_item("d0", it, st0, fi0, fe0, 32'(fa0), 32'(fb0), 32'(cnt0));
            end
            if (q1.size() > 0) begin
                it = q1.pop_front();
                chk_item("d1", it, st1, fi1, fe1, 32'(fa1), 32'(fb1), 32'(cnt1));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; id_rd = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0; ex_branch_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 5; s++) pipe[k][s] = '0;
            cnt_m[k] = 0;
        end
        clr_lit();

        // reset state
        setlit2(0, 0, 0, 0, 0); issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        setlit2(0, 0, 0, 0, 0); issue(1, 1, 5, 5, 1, 1, 5, 1, 1, 0);
        setlit2(0, 0, 0, 0, 0); nop();

        // back-to-back: add x5 ; add x6,x5,x5
        alu(5, 1, 2);
        setlit2(0, 0, 1, 1, -1); alu(6, 5, 5);
        drain();

        // distance 2: add x5 ; nop ; sub x7,x5,x1
        alu(5, 1, 2); nop();
        setlit2(0, 0, 2, 0, -1); alu(7, 5, 1);
        drain();

        // load-use: lw x5 ; add x6,x5,x0 held in ID while stalled
        lw(5, 1);
        setlit2(1, 0, -1, -1, -1);                                    alu(6, 5, 0);
        setlit(0, 0, 0, 2, 0, -1); setlit(1, 1, 0, -1, -1, -1);       alu(6, 5, 0);
        setlit(1, 0, 0, 3, 0, -1);                                    alu(6, 5, 0);
        setlit(0, -1, -1, -1, -1, 1); setlit(1, -1, -1, -1, -1, 2);   nop();
        drain();

        // youngest producer wins, and x0 never forwards
        alu(5, 1, 2); alu(5, 1, 2);
        setlit2(0, 0, 1, 0, -1); alu(8, 5, 0);
        drain();
        alu(0, 1, 2); alu(0, 1, 2);
        setlit2(0, 0, 0, 0, -1); alu(8, 0, 0);
        drain();

        // flush beats a pending load-use, entry 0 becomes a bubble
        lw(5, 1);
        setlit2(0, 1, -1, -1, -1); issue(0, 1, 5, 0, 1, 1, 6, 1, 0, 1);
        setlit(0, 0, 0, 2, 0, -1); setlit(1, 1, 0, -1, -1, -1); alu(6, 5, 0);
        drain();

        // reset in the middle of a load-use stall
        lw(5, 1);
        setlit2(1, 0, -1, -1, -1); alu(6, 5, 0);
        setlit2(0, 0, 0, 0, 0);    issue(1, 1, 5, 0, 1, 1, 6, 1, 0, 0);
        setlit2(0, 0, 0, 0, 0);    alu(6, 5, 0);
        drain();

        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            bit r;
            r = ($urandom_range(0, 199) < 3);
            issue(r, $urandom_range(0, 9) != 0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  int'($urandom_range(0, 3)), $urandom_range(0, 4) != 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
        end

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q0.size() + q1.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
